// File: rtl/tm1638_frame_sched.sv
// TM1638 frame scheduler: drives the byte-level serial engine through key scan,
// write-mode, 16-byte display burst and display-control commands, then repeats.
module tm1638_frame_sched #(
  parameter int unsigned REFRESH_DIV = 120000,
  parameter int unsigned CS_GAP      = 2,
  parameter int unsigned RD_WAIT     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buf_we,
  input  logic [3:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic [2:0] brightness,
  input  logic       disp_on,
  input  logic       frame_req,
  input  logic       tm_busy,
  input  logic [7:0] tm_in,
  output logic       tm_cs,
  output logic       tm_rw,
  output logic       tm_latch,
  output logic [7:0] tm_out,
  output logic [7:0] keys,
  output logic       keys_chg,
  output logic       frame_done,
  output logic       active
);

  localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(CS_GAP - 1);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(RD_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY_CMD, S_KEY_WAIT, S_KEY_RD, S_WR_MODE,
    S_ADDR, S_DATA, S_DCTL, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_START, PH_LATCH, PH_BLIND, PH_WAIT, PH_RISE
  } phase_t;

  state_t        state_q;
  phase_t        ph_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;
  logic [WW-1:0] wait_q;
  logic [3:0]    idx_q;
  logic          pend_q;
  logic          cs_q;
  logic          rw_q;
  logic          latch_q;
  logic [7:0]    out_q;
  logic [7:0]    keys_q;
  logic [7:0]    key_sh_q;
  logic          keys_chg_q;
  logic          frame_done_q;
  logic          active_q;
  logic [7:0]    buf_q  [16];
  logic [7:0]    snap_q [16];

  logic [7:0]    cmd_byte;
  state_t        after_rise;
  logic [7:0]    keys_d;
  logic          unused_tm_in;

  assign unused_tm_in = ^{tm_in[7:5], tm_in[3:1]};

  assign tm_cs      = cs_q;
  assign tm_rw      = rw_q;
  assign tm_latch   = latch_q;
  assign tm_out     = out_q;
  assign keys       = keys_q;
  assign keys_chg   = keys_chg_q;
  assign frame_done = frame_done_q;
  assign active     = active_q;

  always_comb begin
    cmd_byte = 8'h42;
    case (state_q)
      S_WR_MODE: cmd_byte = 8'h40;
      S_ADDR:    cmd_byte = 8'hC0;
      S_DCTL:    cmd_byte = {(disp_on ? 5'b10001 : 5'b10000), brightness};
      default:   cmd_byte = 8'h42;
    endcase
  end

  always_comb begin
    after_rise = S_DONE;
    case (state_q)
      S_KEY_RD:  after_rise = S_WR_MODE;
      S_WR_MODE: after_rise = S_ADDR;
      S_DATA:    after_rise = S_DCTL;
      default:   after_rise = S_DONE;
    endcase
  end

  // Byte 3 supplies keys S4/S8 directly so the update lands in the completion cycle.
  always_comb begin
    keys_d    = key_sh_q;
    keys_d[3] = tm_in[0];
    keys_d[7] = tm_in[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[buf_addr] <= buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ph_q         <= PH_START;
      timer_q      <= '0;
      gap_q        <= '0;
      wait_q       <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      cs_q         <= 1'b1;
      rw_q         <= 1'b1;
      latch_q      <= 1'b0;
      out_q        <= '0;
      keys_q       <= '0;
      key_sh_q     <= '0;
      keys_chg_q   <= 1'b0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) snap_q[i] <= '0;
    end else begin
      latch_q      <= 1'b0;
      keys_chg_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - GW'(1);
      if (frame_req && (state_q != S_IDLE)) pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pend_q || frame_req || (timer_q == '0)) begin
            state_q  <= S_KEY_CMD;
            ph_q     <= PH_START;
            active_q <= 1'b1;
            pend_q   <= 1'b0;
            timer_q  <= TIMER_LOAD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        S_KEY_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_KEY_RD;
            ph_q    <= PH_LATCH;
            idx_q   <= '0;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end

        S_DONE: begin
          frame_done_q <= 1'b1;
          active_q     <= 1'b0;
          if (!pend_q) timer_q <= TIMER_LOAD;
          state_q      <= S_IDLE;
        end

        default: begin
          case (ph_q)
            PH_START: begin
              if (gap_q == '0) begin
                cs_q  <= 1'b0;
                out_q <= cmd_byte;
                idx_q <= '0;
                ph_q  <= PH_LATCH;
              end
            end
            PH_LATCH: begin
              if (!tm_busy) begin
                latch_q <= 1'b1;
                ph_q    <= PH_BLIND;
              end
            end
            PH_BLIND: ph_q <= PH_WAIT;
            PH_WAIT: begin
              if (!tm_busy) begin
                case (state_q)
                  S_KEY_CMD: begin
                    rw_q    <= 1'b0;
                    wait_q  <= WAIT_LOAD;
                    state_q <= S_KEY_WAIT;
                  end
                  S_KEY_RD: begin
                    key_sh_q[{1'b0, idx_q[1:0]}] <= tm_in[0];
                    key_sh_q[{1'b1, idx_q[1:0]}] <= tm_in[4];
                    if (idx_q == 4'd3) begin
                      keys_q     <= keys_d;
                      keys_chg_q <= (keys_d != keys_q);
                      ph_q       <= PH_RISE;
                    end else begin
                      idx_q <= idx_q + 4'd1;
                      ph_q  <= PH_LATCH;
                    end
                  end
                  S_ADDR: begin
                    // Snapshot and first data byte both come from the pre-write buffer.
                    for (int unsigned i = 0; i < 16; i++) snap_q[i] <= buf_q[i];
                    out_q   <= buf_q[0];
                    idx_q   <= '0;
                    state_q <= S_DATA;
                    ph_q    <= PH_LATCH;
                  end
                  S_DATA: begin
                    if (idx_q == 4'd15) begin
                      ph_q <= PH_RISE;
                    end else begin
                      out_q <= snap_q[idx_q + 4'd1];
                      idx_q <= idx_q + 4'd1;
                      ph_q  <= PH_LATCH;
                    end
                  end
                  default: ph_q <= PH_RISE;
                endcase
              end
            end
            PH_RISE: begin
              cs_q    <= 1'b1;
              rw_q    <= 1'b1;
              gap_q   <= GAP_LOAD;
              state_q <= after_rise;
              ph_q    <= PH_START;
            end
            default: ph_q <= PH_START;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Scoreboard bench for tm1638_frame_sched with a fixed-latency serial engine model.
module tb_tm1638_frame_sched;

  localparam int unsigned REFRESH_DIV = 3000;
  localparam int unsigned CS_GAP      = 2;
  localparam int unsigned RD_WAIT     = 12;
  localparam int          B           = 16;
  // 24 latched bytes of B+3 cycles, the read wait, rise+gap after three windows, rise+DONE after the last.
  localparam int FRAME_LEN = 24 * (B + 3) + RD_WAIT + 3 * (1 + CS_GAP) + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buf_we;
  logic [3:0] buf_addr;
  logic [7:0] buf_wdata;
  logic [2:0] brightness;
  logic       disp_on;
  logic       frame_req;
  logic       tm_busy;
  logic [7:0] tm_in;
  logic       tm_cs, tm_rw, tm_latch;
  logic [7:0] tm_out, keys;
  logic       keys_chg, frame_done, active;

  int total = 0;
  int bad   = 0;

  logic [8:0]  byte_q [$];
  logic [15:0] frame_q [$];
  logic [7:0]  model_buf [16];
  logic [7:0]  rd_bytes [4];

  tm1638_frame_sched #(
    .REFRESH_DIV(REFRESH_DIV),
    .CS_GAP(CS_GAP),
    .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .brightness(brightness), .disp_on(disp_on),
    .frame_req(frame_req), .tm_busy(tm_busy), .tm_in(tm_in),
    .tm_cs(tm_cs), .tm_rw(tm_rw), .tm_latch(tm_latch), .tm_out(tm_out),
    .keys(keys), .keys_chg(keys_chg), .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Engine model: busy for B cycles after each latch, read data presented at latch.
  int eng_cnt;
  int rdk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_busy <= 1'b0; eng_cnt <= 0; rdk <= 0; tm_in <= 8'h00;
    end else if (tm_latch) begin
      tm_busy <= 1'b1;
      eng_cnt <= B - 1;
      if (!tm_rw) begin
        tm_in <= rd_bytes[rdk];
        rdk   <= (rdk + 1) % 4;
      end
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end else begin
      tm_busy <= 1'b0;
    end
  end

  // Monitor: pops expected bytes on each latch, expected frame results on frame_done.
  int         hi_run = 100;
  logic       prev_cs = 1'b1;
  int         fr_cs, fr_chg, fr_len;
  bit         counting;
  logic [7:0] last_out;
  logic [8:0] be;
  logic [15:0] fe;
  always @(negedge clk) begin
    if (!rst_n) begin
      fr_cs = 0; fr_chg = 0; fr_len = 0; counting = 0;
      if (tm_cs) hi_run++;
      prev_cs = tm_cs;
    end else begin
      if (counting) fr_len++;
      if (tm_cs) begin
        hi_run++;
      end else begin
        if (prev_cs) begin
          chk("cs_gap", 32'(hi_run >= int'(CS_GAP)), 1);
          if (!counting) begin counting = 1; fr_len = 0; end
          fr_cs++;
        end
        hi_run = 0;
      end
      if (tm_latch) begin
        chk("latch_busy", tm_busy, 0);
        chk("latch_cs", {prev_cs, tm_cs}, 0);
        chk("latch_active", active, 1);
        if (byte_q.size() == 0) begin
          chk("byte_unexpected", 0, 1);
        end else begin
          be = byte_q.pop_front();
          chk("latch_rw", tm_rw, be[8]);
          if (be[8]) chk("latch_byte", tm_out, be[7:0]);
        end
        last_out = tm_out;
      end else if (tm_busy) begin
        chk("out_stable", tm_out, last_out);
      end
      prev_cs = tm_cs;
      if (keys_chg) fr_chg++;
      if (frame_done) begin
        if (frame_q.size() == 0) begin
          chk("frame_unexpected", 0, 1);
        end else begin
          fe = frame_q.pop_front();
          chk("keys", keys, fe[15:8]);
          chk("keys_chg_count", fr_chg, fe[7:0]);
        end
        chk("cmd_windows", fr_cs, 4);
        chk("frame_len", fr_len, FRAME_LEN);
        chk("active_at_done", active, 0);
        fr_cs = 0; fr_chg = 0; counting = 0;
      end
    end
  end

  task automatic push_frame(input logic [7:0] dctl, input logic [7:0] k, input logic [7:0] nchg);
    byte_q.push_back({1'b1, 8'h42});
    for (int i = 0; i < 4; i++) byte_q.push_back({1'b0, 8'h00});
    byte_q.push_back({1'b1, 8'h40});
    byte_q.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 16; i++) byte_q.push_back({1'b1, model_buf[i]});
    byte_q.push_back({1'b1, dctl});
    frame_q.push_back({k, nchg});
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    buf_we = 1'b1; buf_addr = a; buf_wdata = d;
    model_buf[a] = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    chk(nm, 32'(seen), 1);
  endtask

  task automatic wait_cs_low(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (!tm_cs) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    int  lat;
    rst_n = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
    brightness = 3'd7; disp_on = 1'b1; frame_req = 1'b0;
    for (int i = 0; i < 16; i++) model_buf[i] = 8'h00;
    for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs", tm_cs, 1);
    chk("rst_rw", tm_rw, 1);
    chk("rst_latch", tm_latch, 0);
    chk("rst_out", tm_out, 0);
    chk("rst_keys", keys, 0);
    chk("rst_active", active, 0);

    // Frame 0: all-zero buffer, disp_on=1, brightness=7.
    push_frame(8'h8F, 8'h00, 8'd0);
    rst_n = 1'b1;
    wait_cs_low(10, n);
    chk("first_cs_fall", 32'(n <= 3), 1);
    wait_done("frame0_done");

    // Frame 1: buffer edits, brightness 2, keys S1,S6,S4,S8 -> 0xA9.
    wr(4'd0, 8'h3F);
    wr(4'd15, 8'h01);
    brightness = 3'd2;
    rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h10; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h11;
    push_frame(8'h8A, 8'hA9, 8'd1);
    pulse_req();
    wait_done("frame1_done");

    // Frame 2 sends old buf[3] despite the snapshot-cycle write; frame 3 is the pending one.
    push_frame(8'h8A, 8'hA9, 8'd0);
    model_buf[3] = 8'h55;
    push_frame(8'h8A, 8'hA9, 8'd0);
    pulse_req();
    found = 0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clk);
      if (tm_latch && tm_out == 8'hC0) found = 1;
    end
    chk("addr_cmd_seen", 32'(found), 1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (tm_busy) found = 1;
    end
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!tm_busy) found = 1;
    end
    chk("addr_cmd_complete", 32'(found), 1);
    buf_we = 1'b1; buf_addr = 4'd3; buf_wdata = 8'h55;
    @(negedge clk);
    buf_we = 1'b0;
    repeat (20) @(negedge clk);
    pulse_req();
    repeat (30) @(negedge clk);
    pulse_req();
    wait_done("frame2_done");
    wait_cs_low(50, n);
    chk("pending_start", 32'(n <= int'(CS_GAP) + 3), 1);
    wait_done("frame3_done");

    // Frame 4 comes only from the refresh timer; a second pending frame would arrive early.
    push_frame(8'h8A, 8'hA9, 8'd0);
    wait_cs_low(4000, n);
    chk("refresh_interval", 32'(n >= int'(REFRESH_DIV) && n <= int'(REFRESH_DIV) + 3), 1);
    wait_done("frame4_done");

    // Frame 5 aborted by reset mid-DATA burst.
    push_frame(8'h8A, 8'hA9, 8'd0);
    pulse_req();
    lat = 0;
    for (int i = 0; i < 1500 && lat < 12; i++) begin
      @(negedge clk);
      if (tm_latch) lat++;
    end
    chk("reached_data", lat, 12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", tm_cs, 1);
    chk("abort_latch", tm_latch, 0);
    chk("abort_keys", keys, 0);
    chk("abort_active", active, 0);
    byte_q.delete();
    frame_q.delete();
    for (int i = 0; i < 16; i++) model_buf[i] = 8'h00;
    push_frame(8'h8A, 8'hA9, 8'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cs_low(10, n);
    chk("restart_cs_fall", 32'(n <= 3), 1);
    wait_done("frame6_done");

    repeat (5) @(negedge clk);
    chk("bytes_left", byte_q.size(), 0);
    chk("frames_left", frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
